water_fill_ctrl: RTL and testbench
==================================

WATER_FILL_CTRL -- requirements
Module: water_fill_ctrl

Interface
REQ-001 Parameter FILL_SECS, default 3: fill seconds per water-level step.
REQ-002 Parameter DRAIN_SECS, default 4: fixed drain duration in seconds.
REQ-003 clk  input  1  single system clock, all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 tick  input  1  one-clk-wide pulse per second, synchronous to clk.
REQ-006 water_level  input  3  selected water amount 0..5 from water_amount current_water.
REQ-007 fill_start  input  1  one-clk pulse requesting a fill cycle.
REQ-008 drain_start  input  1  one-clk pulse requesting a drain cycle.
REQ-009 pause  input  1  level; hold operation (present only with PAUSE_EN).
REQ-010 inlet_valve  output  1  registered; high opens inlet valve.
REQ-011 drain_valve  output  1  registered; high opens drain valve.
REQ-012 busy  output  1  registered; high whenever state is not IDLE.
REQ-013 fill_done  output  1  registered one-clk pulse at fill completion.
REQ-014 drain_done  output  1  registered one-clk pulse at drain completion.
REQ-015 remaining  output  6  registered seconds left in current phase.

Function
REQ-016 States: IDLE, FILL, DRAIN; encoding free, no other reachable states.
REQ-017 IDLE: both valves low, busy low, remaining 0.
REQ-018 fill_start in IDLE: next edge -> FILL, inlet_valve 1, remaining = (min(water_level,5)+1)*FILL_SECS.
REQ-019 water_level 6 or 7 clamped to 5 before multiply; parameters constrained so product <= 63, no truncation.
REQ-020 drain_start in IDLE: next edge -> DRAIN, drain_valve 1, remaining = DRAIN_SECS.
REQ-021 fill_start and drain_start same cycle in IDLE: drain wins, fill request discarded.
REQ-022 fill_start/drain_start while busy: ignored, no queueing.
REQ-023 tick coincident with the start-accepting edge: not counted.
REQ-024 In FILL/DRAIN, each tick decrements remaining by 1; no change without tick.
REQ-025 tick with remaining == 1: next edge remaining 0, valve low, state IDLE, matching done pulse high one cycle.
REQ-026 inlet_valve and drain_valve never high simultaneously.
REQ-027 water_level changes after fill accepted: no effect on running count.
REQ-028 done pulses never asserted except per REQ-025.

Reset
REQ-029 rst_n low: immediately state IDLE, all outputs 0, independent of clk.
REQ-030 Reset mid-FILL/DRAIN: phase aborted, no done pulse, valves closed.
REQ-031 After rst_n release, first start accepted on first rising edge with rst_n high.

Configuration
REQ-032 Macro WATER_FILL_PAUSE_EN defined: pause port present; pause high in FILL/DRAIN closes both valves, freezes remaining and state, ignores tick; pause low resumes same phase, valve reopens next edge.
REQ-033 WATER_FILL_PAUSE_EN defined: pause in IDLE blocks start acceptance; starts while paused discarded.
REQ-034 WATER_FILL_PAUSE_EN undefined: no pause port, behaviour as if pause tied 0.

Verification
REQ-035 water_level=2, FILL_SECS=3, fill_start -> inlet_valve 1, remaining 9; after 9 ticks fill_done 1 clk, inlet_valve 0, busy 0.
REQ-036 water_level=7, fill_start -> remaining 18 (clamped level 5).
REQ-037 fill_start+drain_start same cycle -> DRAIN, remaining 4, inlet_valve stays 0; 4 ticks -> drain_done pulse.
REQ-038 fill running, remaining 5, rst_n low mid-cycle -> outputs 0 without clk edge, no fill_done.
REQ-039 fill running, fill_start/drain_start pulsed at remaining 3 -> ignored, fill completes after 3 more ticks.
REQ-040 WATER_FILL_PAUSE_EN: remaining 6, pause high across 5 ticks -> remaining 6, valves 0; pause low -> inlet_valve 1, 6 ticks to fill_done.

Source files
------------

// File: rtl/water_fill_ctrl.sv
// rtl/water_fill_ctrl.sv - water fill/drain phase controller with per-second countdown
// Optional pause input enabled by defining WATER_FILL_PAUSE_EN.
module water_fill_ctrl #(
   parameter int FILL_SECS  = 3,
   parameter int DRAIN_SECS = 4
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_tick,
   input  logic [2:0] i_water_level,
   input  logic       i_fill_start,
   input  logic       i_drain_start,
`ifdef WATER_FILL_PAUSE_EN
   input  logic       i_pause,
`endif
   output logic       o_inlet_valve,
   output logic       o_drain_valve,
   output logic       o_busy,
   output logic       o_fill_done,
   output logic       o_drain_done,
   output logic [5:0] o_remaining
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_FILL  = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;

   logic [1:0] r_state;
   logic       r_inlet;
   logic       r_drain;
   logic       r_busy;
   logic       r_fill_done;
   logic       r_drain_done;
   logic [5:0] r_remaining;

   logic       w_pause;
   logic [2:0] w_level;
   logic [5:0] w_fill_load;
   logic       w_last;

`ifdef WATER_FILL_PAUSE_EN
   assign w_pause = i_pause;
`else
   assign w_pause = 1'b0;
`endif

   // Levels 6 and 7 are treated as the maximum level 5.
   assign w_level     = (i_water_level > 3'd5) ? 3'd5 : i_water_level;
   assign w_fill_load = ({3'd0, w_level} + 6'd1) * 6'(FILL_SECS);
   assign w_last      = (r_remaining <= 6'd1);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state      <= S_IDLE;
         r_inlet      <= 1'b0;
         r_drain      <= 1'b0;
         r_busy       <= 1'b0;
         r_fill_done  <= 1'b0;
         r_drain_done <= 1'b0;
         r_remaining  <= 6'd0;
      end else begin
         r_fill_done  <= 1'b0;
         r_drain_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (!w_pause) begin
                  if (i_drain_start) begin
                     r_state     <= S_DRAIN;
                     r_drain     <= 1'b1;
                     r_busy      <= 1'b1;
                     r_remaining <= 6'(DRAIN_SECS);
                  end else if (i_fill_start) begin
                     r_state     <= S_FILL;
                     r_inlet     <= 1'b1;
                     r_busy      <= 1'b1;
                     r_remaining <= w_fill_load;
                  end
               end
            end
            S_FILL, S_DRAIN: begin
               if (w_pause) begin
                  r_inlet <= 1'b0;
                  r_drain <= 1'b0;
               end else if (i_tick && w_last) begin
                  r_state      <= S_IDLE;
                  r_inlet      <= 1'b0;
                  r_drain      <= 1'b0;
                  r_busy       <= 1'b0;
                  r_remaining  <= 6'd0;
                  r_fill_done  <= (r_state == S_FILL);
                  r_drain_done <= (r_state == S_DRAIN);
               end else begin
                  // Reopen the phase's valve here so a released pause resumes on this edge.
                  r_inlet <= (r_state == S_FILL);
                  r_drain <= (r_state == S_DRAIN);
                  if (i_tick) begin
                     r_remaining <= r_remaining - 6'd1;
                  end
               end
            end
            default: begin
               r_state     <= S_IDLE;
               r_inlet     <= 1'b0;
               r_drain     <= 1'b0;
               r_busy      <= 1'b0;
               r_remaining <= 6'd0;
            end
         endcase
      end
   end

   assign o_inlet_valve = r_inlet;
   assign o_drain_valve = r_drain;
   assign o_busy        = r_busy;
   assign o_fill_done   = r_fill_done;
   assign o_drain_done  = r_drain_done;
   assign o_remaining   = r_remaining;

endmodule

// File: tb/tb_water_fill_ctrl.sv
// tb/tb_water_fill_ctrl.sv - self-checking bench for water_fill_ctrl
module tb_water_fill_ctrl;

   localparam int FS = 3;
   localparam int DS = 4;

   typedef struct {
      bit is_fill;
      int load;
   } exp_t;

   exp_t exp_q[$];
   int   errors = 0;
   int   checks = 0;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       tick = 1'b0;
   logic [2:0] level = 3'd0;
   logic       fill_start = 1'b0;
   logic       drain_start = 1'b0;
`ifdef WATER_FILL_PAUSE_EN
   logic       pause = 1'b0;
`endif
   logic       inlet_valve;
   logic       drain_valve;
   logic       busy;
   logic       fill_done;
   logic       drain_done;
   logic [5:0] remaining;

   water_fill_ctrl #(.FILL_SECS(FS), .DRAIN_SECS(DS)) dut (
      .i_clk         (clk),
      .i_rst_n       (rst_n),
      .i_tick        (tick),
      .i_water_level (level),
      .i_fill_start  (fill_start),
      .i_drain_start (drain_start),
`ifdef WATER_FILL_PAUSE_EN
      .i_pause       (pause),
`endif
      .o_inlet_valve (inlet_valve),
      .o_drain_valve (drain_valve),
      .o_busy        (busy),
      .o_fill_done   (fill_done),
      .o_drain_done  (drain_done),
      .o_remaining   (remaining)
   );

   always #5 clk = ~clk;

   function automatic int model_load(input bit is_fill, input int lvl);
      if (!is_fill) return DS;
      return ((lvl > 5 ? 5 : lvl) + 1) * FS;
   endfunction

   task automatic edge1;
      @(posedge clk);
      #1;
   endtask

   task automatic do_tick;
      tick = 1'b1;
      edge1;
      tick = 1'b0;
   endtask

   task automatic start_op(input string name, input bit f, input bit d, input int lvl, input bit with_tick);
      exp_t e;
      e.is_fill = !d;
      e.load    = model_load(!d, lvl);
      exp_q.push_back(e);
      level       = 3'(lvl);
      fill_start  = f;
      drain_start = d;
      tick        = with_tick;
      edge1;
      fill_start  = 1'b0;
      drain_start = 1'b0;
      tick        = 1'b0;
      checks++;
      if ({remaining, inlet_valve, drain_valve, busy} !== {6'(e.load), e.is_fill, !e.is_fill, 1'b1}) begin
         errors++;
         $display("FAIL %s_accept: rem=%0d in=%0b dr=%0b busy=%0b required rem=%0d in=%0b dr=%0b busy=1",
                  name, remaining, inlet_valve, drain_valve, busy, e.load, e.is_fill, !e.is_fill);
      end
   endtask

   task automatic run_to_done(input string name, input int budget);
      exp_t e;
      int   n;
      bit   seen;
      n    = 0;
      seen = 0;
      if (exp_q.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL %s_queue: scoreboard empty, required one pending phase", name);
         return;
      end
      e = exp_q[0];
      while (!seen && n < budget) begin
         do_tick;
         n++;
         if (fill_done || drain_done) begin
            seen = 1;
            e = exp_q.pop_front();
            checks++;
            if (n !== e.load) begin
               errors++;
               $display("FAIL %s_ticks: done after %0d ticks, required %0d", name, n, e.load);
            end
            checks++;
            if ({fill_done, drain_done} !== {e.is_fill, !e.is_fill}) begin
               errors++;
               $display("FAIL %s_kind: fill_done=%0b drain_done=%0b required %0b/%0b",
                        name, fill_done, drain_done, e.is_fill, !e.is_fill);
            end
            checks++;
            if ({inlet_valve, drain_valve, busy, remaining} !== 9'd0) begin
               errors++;
               $display("FAIL %s_idle: in=%0b dr=%0b busy=%0b rem=%0d required all 0",
                        name, inlet_valve, drain_valve, busy, remaining);
            end
            edge1;
            checks++;
            if ({fill_done, drain_done} !== 2'b00) begin
               errors++;
               $display("FAIL %s_pulse_width: done=%0b%0b one cycle later, required 00",
                        name, fill_done, drain_done);
            end
         end else begin
            checks++;
            if ({remaining, inlet_valve & drain_valve} !== {6'(e.load - n), 1'b0}) begin
               errors++;
               $display("FAIL %s_count: rem=%0d overlap=%0b required rem=%0d overlap=0",
                        name, remaining, inlet_valve & drain_valve, e.load - n);
            end
            edge1;
            checks++;
            if (remaining !== 6'(e.load - n)) begin
               errors++;
               $display("FAIL %s_hold: rem=%0d without tick, required %0d", name, remaining, e.load - n);
            end
         end
      end
      if (!seen) begin
         checks++;
         errors++;
         $display("FAIL %s_timeout: no done pulse within %0d ticks", name, budget);
      end
   endtask

   task automatic test_reset;
      #3;
      checks++;
      if ({inlet_valve, drain_valve, busy, fill_done, drain_done, remaining} !== 11'd0) begin
         errors++;
         $display("FAIL reset_state: outputs=%b required all 0",
                  {inlet_valve, drain_valve, busy, fill_done, drain_done, remaining});
      end
      edge1;
      rst_n = 1'b1;
   endtask

   task automatic test_fill_basic;
      start_op("fill_l2", 1'b1, 1'b0, 2, 1'b1);
      run_to_done("fill_l2", 40);
   endtask

   task automatic test_clamp;
      start_op("fill_l7", 1'b1, 1'b0, 7, 1'b0);
      run_to_done("fill_l7", 40);
      start_op("fill_l0", 1'b1, 1'b0, 0, 1'b0);
      run_to_done("fill_l0", 40);
   endtask

   task automatic test_both_starts;
      start_op("both", 1'b1, 1'b1, 3, 1'b0);
      run_to_done("both", 40);
   endtask

   task automatic test_reset_mid;
      start_op("rst_mid", 1'b1, 1'b0, 4, 1'b0);
      for (int i = 0; i < 10; i++) do_tick;
      checks++;
      if (remaining !== 6'd5) begin
         errors++;
         $display("FAIL rst_mid_pre: rem=%0d required 5", remaining);
      end
      #2;
      rst_n = 1'b0;
      void'(exp_q.pop_front());
      #1;
      checks++;
      if ({inlet_valve, drain_valve, busy, fill_done, drain_done, remaining} !== 11'd0) begin
         errors++;
         $display("FAIL rst_mid_async: outputs=%b required all 0 before clock edge",
                  {inlet_valve, drain_valve, busy, fill_done, drain_done, remaining});
      end
      for (int i = 0; i < 3; i++) do_tick;
      #2;
      rst_n = 1'b1;
      checks++;
      if ({fill_done, busy} !== 2'b00) begin
         errors++;
         $display("FAIL rst_mid_nodone: fill_done=%0b busy=%0b required 0/0", fill_done, busy);
      end
      start_op("rst_first", 1'b0, 1'b1, 0, 1'b0);
      run_to_done("rst_first", 40);
   endtask

   task automatic test_ignore_busy;
      start_op("busy_ign", 1'b1, 1'b0, 2, 1'b0);
      for (int i = 0; i < 6; i++) do_tick;
      fill_start = 1'b1;
      edge1;
      fill_start  = 1'b0;
      drain_start = 1'b1;
      edge1;
      drain_start = 1'b0;
      checks++;
      if ({remaining, inlet_valve, drain_valve} !== {6'd3, 1'b1, 1'b0}) begin
         errors++;
         $display("FAIL busy_ign_state: rem=%0d in=%0b dr=%0b required 3/1/0",
                  remaining, inlet_valve, drain_valve);
      end
      exp_q[0].load = 3;
      run_to_done("busy_ign", 20);
      edge1;
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL busy_ign_noqueue: busy=%0b required 0", busy);
      end
   endtask

`ifdef WATER_FILL_PAUSE_EN
   task automatic test_pause;
      start_op("pause", 1'b1, 1'b0, 1, 1'b0);
      pause = 1'b1;
      for (int i = 0; i < 5; i++) begin
         do_tick;
         checks++;
         if ({remaining, inlet_valve, drain_valve, busy} !== {6'd6, 1'b0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL pause_hold: rem=%0d in=%0b dr=%0b busy=%0b required 6/0/0/1",
                     remaining, inlet_valve, drain_valve, busy);
         end
      end
      pause = 1'b0;
      edge1;
      checks++;
      if ({remaining, inlet_valve} !== {6'd6, 1'b1}) begin
         errors++;
         $display("FAIL pause_resume: rem=%0d in=%0b required 6/1", remaining, inlet_valve);
      end
      run_to_done("pause", 20);
      pause      = 1'b1;
      fill_start = 1'b1;
      edge1;
      fill_start = 1'b0;
      pause      = 1'b0;
      edge1;
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL pause_idle_block: busy=%0b required 0", busy);
      end
   endtask
`endif

   initial begin
      test_reset;
      test_fill_basic;
      test_clamp;
      test_both_starts;
      test_reset_mid;
      test_ignore_busy;
`ifdef WATER_FILL_PAUSE_EN
      test_pause;
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
